// File: rtl/alu_pkg.sv
// alu_pipe shared types: opcode encoding, flag bundle and flag bit indices.
// Flags are only built when ALU_PIPE_FLAGS_EN is defined.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_SLL = 3'b011,
    OP_OR  = 3'b100,
    OP_NOR = 3'b101,
    OP_XOR = 3'b110,
    OP_SRL = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic negative;
    logic zero;
  } alu_flags_t;

  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath between the S1 and S2 registers of alu_pipe.
// Flag outputs exist only when ALU_PIPE_FLAGS_EN is defined.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  alu_op_e          op_i,
  output logic [WIDTH-1:0] res_o
`ifdef ALU_PIPE_FLAGS_EN
  ,
  output alu_flags_t       flags_o
`endif
);

  localparam logic [WIDTH-1:0] WLIM = WIDTH'(WIDTH);
  localparam int M = WIDTH - 1;

  logic             sh_big;
  logic [SHW-1:0]   amt;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] shl;
  logic [WIDTH-1:0] shr;

  assign sh_big = (b_i >= WLIM);
  assign amt    = b_i[SHW-1:0];

`ifdef ALU_PIPE_FLAGS_EN
  // One extra bit catches carry/borrow and the last bit shifted out.
  logic [WIDTH:0] add_w;
  logic [WIDTH:0] sub_w;
  logic [WIDTH:0] sll_w;
  logic [WIDTH:0] srl_w;

  assign add_w = {1'b0, a_i} + {1'b0, b_i};
  assign sub_w = {1'b0, a_i} - {1'b0, b_i};
  assign sll_w = sh_big ? '0 : ({1'b0, a_i} << amt);
  assign srl_w = sh_big ? '0 : ({a_i, 1'b0} >> amt);

  assign sum  = add_w[WIDTH-1:0];
  assign diff = sub_w[WIDTH-1:0];
  assign shl  = sll_w[WIDTH-1:0];
  assign shr  = srl_w[WIDTH:1];
`else
  assign sum  = a_i + b_i;
  assign diff = a_i - b_i;
  assign shl  = sh_big ? '0 : (a_i << amt);
  assign shr  = sh_big ? '0 : (a_i >> amt);
`endif

  always_comb begin
    res_o = '0;
    unique case (op_i)
      OP_ADD: res_o = sum;
      OP_SUB: res_o = diff;
      OP_AND: res_o = a_i & b_i;
      OP_SLL: res_o = shl;
      OP_OR:  res_o = a_i | b_i;
      OP_NOR: res_o = ~(a_i | b_i);
      OP_XOR: res_o = a_i ^ b_i;
      OP_SRL: res_o = shr;
    endcase
  end

`ifdef ALU_PIPE_FLAGS_EN
  always_comb begin
    flags_o = '0;
    unique case (op_i)
      OP_ADD: begin
        flags_o.carry    = add_w[WIDTH];
        flags_o.overflow = (a_i[M] == b_i[M]) &&
                           (sum[M] != a_i[M]);
      end
      OP_SUB: begin
        flags_o.carry    = sub_w[WIDTH];
        flags_o.overflow = (a_i[M] != b_i[M]) &&
                           (diff[M] != a_i[M]);
      end
      OP_SLL:  flags_o.carry = sll_w[WIDTH];
      OP_SRL:  flags_o.carry = srl_w[0];
      default: ;
    endcase
    flags_o.negative = res_o[M];
    flags_o.zero     = (res_o == '0);
  end
`endif

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshake and global stall.
// Define ALU_PIPE_FLAGS_EN to build the flag logic; otherwise flags = 0.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  logic             advance;
  logic             s1_vld_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  alu_op_e          s1_op_q;
  logic             out_vld_q;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] res_q;

  // Whole pipe moves together; bubbles are kept, not squeezed out.
  assign advance   = !out_vld_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = out_vld_q;
  assign result    = res_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s1_op_q  <= OP_ADD;
    end else if (advance) begin
      s1_vld_q <= in_valid;
      s1_a_q   <= a;
      s1_b_q   <= b;
      s1_op_q  <= alu_op_e'(op);
    end
  end

`ifdef ALU_PIPE_FLAGS_EN
  alu_flags_t flags_d;
  alu_flags_t flags_q;

  alu_core #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_core (
    .a_i     (s1_a_q),
    .b_i     (s1_b_q),
    .op_i    (s1_op_q),
    .res_o   (res_d),
    .flags_o (flags_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
    end else if (advance) begin
      flags_q <= flags_d;
    end
  end

  assign flags = flags_q;
`else
  alu_core #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_core (
    .a_i   (s1_a_q),
    .b_i   (s1_b_q),
    .op_i  (s1_op_q),
    .res_o (res_d)
  );

  assign flags = 4'b0000;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q <= 1'b0;
      res_q     <= '0;
    end else if (advance) begin
      out_vld_q <= s1_vld_q;
      res_q     <= res_d;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (WIDTH=8 and WIDTH=16).
// Expected flags are zero unless ALU_PIPE_FLAGS_EN is defined.
module tb_alu_pipe;

`ifdef ALU_PIPE_FLAGS_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] AND = 3'b010;
  localparam logic [2:0] SLL = 3'b011;
  localparam logic [2:0] OR  = 3'b100;
  localparam logic [2:0] NOR = 3'b101;
  localparam logic [2:0] XOR = 3'b110;
  localparam logic [2:0] SRL = 3'b111;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] a, b, result;
  logic [2:0] op;
  logic [3:0] flags;

  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0] a16, b16, result16;
  logic [2:0]  op16;
  logic [3:0]  flags16;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  alu_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .op(op16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .result(result16), .flags(flags16)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = ADD;
    in_valid16 = 1'b0; out_ready16 = 1'b1;
    a16 = '0; b16 = '0; op16 = ADD;
    step(); step();
    rst = 1'b0;
    step();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    tests++;
    if (result !== 8'h00) begin
      fails++; $display("FAIL reset_result got %h want 00", result);
    end
    tests++;
    if (flags !== 4'b0000) begin
      fails++; $display("FAIL reset_flags got %b want 0000", flags);
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_ops;
    logic [2:0] to[14] = '{ADD, SUB, SUB, SLL, SRL, SRL, AND,
                           OR, XOR, NOR, SRL, SLL, ADD, SLL};
    logic [7:0] ta[14] = '{8'hFF, 8'h80, 8'h01, 8'h81, 8'h81, 8'h81, 8'hF0,
                           8'h0F, 8'hAA, 8'h00, 8'h81, 8'h81, 8'h7F, 8'h81};
    logic [7:0] tb[14] = '{8'h01, 8'h01, 8'h02, 8'h01, 8'h08, 8'h00, 8'h3C,
                           8'h30, 8'hAA, 8'h00, 8'h01, 8'h07, 8'h01, 8'hF1};
    logic [7:0] tr[14] = '{8'h00, 8'h7F, 8'hFF, 8'h02, 8'h00, 8'h81, 8'h30,
                           8'h3F, 8'h00, 8'hFF, 8'h40, 8'h80, 8'h80, 8'h00};
    logic [3:0] tf[14] = '{4'b1001, 4'b0100, 4'b1010, 4'b1000, 4'b0001,
                           4'b0010, 4'b0000, 4'b0000, 4'b0001, 4'b0010,
                           4'b1000, 4'b0010, 4'b0110, 4'b0001};
    logic [3:0] ef;
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      in_valid = 1'b1; op = to[i]; a = ta[i]; b = tb[i];
      step();
      in_valid = 1'b0;
      tests++;
      if (out_valid !== 1'b0) begin
        fails++; $display("FAIL op%0d_early_valid got %b want 0", i, out_valid);
      end
      step();
      ef = FE ? tf[i] : 4'b0000;
      tests++;
      if (out_valid !== 1'b1) begin
        fails++; $display("FAIL op%0d_valid got %b want 1", i, out_valid);
      end
      tests++;
      if (result !== tr[i]) begin
        fails++; $display("FAIL op%0d_result got %h want %h", i, result, tr[i]);
      end
      tests++;
      if (flags !== ef) begin
        fails++; $display("FAIL op%0d_flags got %b want %b", i, flags, ef);
      end
    end
    step();
  endtask

  task automatic test_back_to_back;
    logic [2:0] xo[5] = '{ADD, SUB, XOR, SLL, OR};
    logic [7:0] xa[5] = '{8'h10, 8'h50, 8'hF0, 8'h03, 8'h40};
    logic [7:0] xb[5] = '{8'h20, 8'h08, 8'hFF, 8'h02, 8'h02};
    logic [7:0] xr[5] = '{8'h30, 8'h48, 8'h0F, 8'h0C, 8'h42};
    int sent = 0;
    int got = 0;
    int stall = 0;
    int cyc = 0;
    bit seen = 1'b0;
    out_ready = 1'b1;
    while (got < 5 && cyc < 60) begin
      if (sent < 5) begin
        in_valid = 1'b1; op = xo[sent]; a = xa[sent]; b = xb[sent];
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid) seen = 1'b1;
      if (seen && stall < 3 && got == 0) begin
        out_ready = 1'b0; stall++;
      end else begin
        out_ready = 1'b1;
      end
      #1;
      if (!out_ready) begin
        tests++;
        if (in_ready !== 1'b0) begin
          fails++; $display("FAIL b2b_stall_in_ready got %b want 0", in_ready);
        end
        tests++;
        if (out_valid !== 1'b1 || result !== xr[0]) begin
          fails++;
          $display("FAIL b2b_hold got v=%b r=%h want v=1 r=%h",
                   out_valid, result, xr[0]);
        end
      end
      if (out_valid && out_ready) begin
        tests++;
        if (result !== xr[got]) begin
          fails++;
          $display("FAIL b2b_result%0d got %h want %h", got, result, xr[got]);
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
      step();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tests++;
    if (got != 5 || stall != 3) begin
      fails++;
      $display("FAIL b2b_count got %0d results/%0d stalls want 5/3", got, stall);
    end
    repeat (3) begin
      tests++;
      if (out_valid !== 1'b0) begin
        fails++; $display("FAIL b2b_extra got valid %b want 0", out_valid);
      end
      step();
    end
  endtask

  task automatic test_reset_midflight;
    out_ready = 1'b1;
    in_valid = 1'b1; op = ADD; a = 8'h01; b = 8'h01;
    step();
    op = ADD; a = 8'h02; b = 8'h02;
    step();
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || result !== 8'h02) begin
      fails++;
      $display("FAIL mid_pre got v=%b r=%h want v=1 r=02", out_valid, result);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || result !== 8'h00 || flags !== 4'b0000) begin
      fails++;
      $display("FAIL mid_rst got v=%b r=%h f=%b want v=0 r=00 f=0000",
               out_valid, result, flags);
    end
    repeat (3) begin
      step();
      tests++;
      if (out_valid !== 1'b0) begin
        fails++; $display("FAIL mid_stale got valid %b want 0", out_valid);
      end
    end
  endtask

  task automatic test_width16;
    logic [2:0]  wo[5] = '{ADD, NOR, XOR, SLL, SRL};
    logic [15:0] wa[5] = '{16'hFFFF, 16'h00FF, 16'h1234, 16'h0001, 16'h8000};
    logic [15:0] wb[5] = '{16'h0001, 16'h0F00, 16'hFFFF, 16'h000F, 16'h0010};
    logic [15:0] wr[5] = '{16'h0000, 16'hF000, 16'hEDCB, 16'h8000, 16'h0000};
    logic [3:0]  wf[5] = '{4'b1001, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
    logic [3:0]  ef;
    out_ready16 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid16 = 1'b1; op16 = wo[i]; a16 = wa[i]; b16 = wb[i];
      step();
      in_valid16 = 1'b0;
      step();
      ef = FE ? wf[i] : 4'b0000;
      tests++;
      if (out_valid16 !== 1'b1 || result16 !== wr[i]) begin
        fails++;
        $display("FAIL w16_op%0d got v=%b r=%h want v=1 r=%h",
                 i, out_valid16, result16, wr[i]);
      end
      tests++;
      if (flags16 !== ef) begin
        fails++; $display("FAIL w16_flags%0d got %b want %b", i, flags16, ef);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_back_to_back();
    test_reset_midflight();
    test_width16();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
